// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one registered single-port memory,
// with a wait-cycle watchdog. Define ARB_RR_EN for round-robin instead of fixed data priority.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic [3:0]  d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        m_req,
   output logic [3:0]  m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        err
);

   typedef enum logic [2:0] {StIdle, StBusyI, StBusyD, StAckI, StAckD} state_e;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
   localparam logic       WdogEn     = (TIMEOUT != 0);

   state_e      state_q, state_d;
   logic        m_req_q, m_req_d;
   logic [3:0]  m_we_q, m_we_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        pick_d;

`ifdef ARB_RR_EN
   // Pointer holds the last-granted port; reset value makes data win the first tie.
   logic last_d_q, last_d_d;

   assign pick_d = d_req & (~i_req | ~last_d_q);

   always_comb begin
      last_d_d = last_d_q;
      if (state_q == StIdle && (i_req || d_req)) last_d_d = pick_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_d_q <= 1'b0;
      else     last_d_q <= last_d_d;
   end
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      err_d     = err_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_d) begin
               m_req_d   = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               cnt_d     = 8'd0;
               state_d   = StBusyD;
            end else if (i_req) begin
               m_req_d  = 1'b1;
               m_we_d   = 4'b0000;
               m_addr_d = i_addr;
               cnt_d    = 8'd0;
               state_d  = StBusyI;
            end
         end
         StBusyI, StBusyD: begin
            if (m_ack) begin
               m_req_d = 1'b0;
               m_we_d  = 4'b0000;
               if (state_q == StBusyI) begin
                  i_rdata_d = m_rdata;
                  i_ack_d   = 1'b1;
                  state_d   = StAckI;
               end else begin
                  // Stores leave the previous load data in place.
                  if (m_we_q == 4'b0000) d_rdata_d = m_rdata;
                  d_ack_d = 1'b1;
                  state_d = StAckD;
               end
            end else if (WdogEn && cnt_q == TimeoutCnt) begin
               m_req_d = 1'b0;
               err_d   = 1'b1;
               if (state_q == StBusyI) begin
                  i_rdata_d = 32'h0;
                  i_ack_d   = 1'b1;
                  state_d   = StAckI;
               end else begin
                  d_rdata_d = 32'h0;
                  d_ack_d   = 1'b1;
                  state_d   = StAckD;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StAckI, StAckD: state_d = StIdle;
         default:        state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         m_req_q   <= 1'b0;
         m_we_q    <= 4'b0000;
         m_addr_q  <= 32'h0;
         m_wdata_q <= 32'h0;
         i_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected acks are queued at stimulus time and
// popped when the DUT acknowledges; a bench memory model supplies wait states.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        m_req;
   logic [3:0]  m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        err;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .err     (err)
   );

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_wait = 0;
   bit          mem_en = 1'b1;
   bit          stray = 1'b0;
   int          mcnt = 0;
   logic [31:0] exp_drd;
   int          reqc;
   bit          got;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      if (a == 32'h100) return 32'h00500093;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Memory model: acks after mem_wait wait cycles; stray forces an unsolicited ack.
   always @(negedge clk) begin
      m_ack   <= stray;
      m_rdata <= 32'hBAD0BAD0;
      if (!rst && m_req && mem_en) begin
         if (mcnt == mem_wait) begin
            m_ack   <= 1'b1;
            m_rdata <= mdata(m_addr);
            mcnt    <= 0;
         end else begin
            mcnt <= mcnt + 1;
         end
      end else begin
         mcnt <= 0;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst && (i_ack || d_ack)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_ack", {30'b0, i_ack, d_ack}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("ack_port", {30'b0, i_ack, d_ack}, mon_e.is_d ? 32'd1 : 32'd2);
            check_eq("ack_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.data);
         end
      end
   end

   task automatic wait_acks(input int n, input bit chk_gap);
      int seen = 0;
      int last = 0;
      for (int cyc = 0; cyc < 200 && seen < n; cyc++) begin
         @(negedge clk);
         if (i_ack || d_ack) begin
            if (chk_gap && seen > 0) check_eq("ack_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            seen++;
         end
      end
      if (seen < n) check_eq("ack_count", 32'(seen), 32'(n));
   endtask

   task automatic release_reqs();
      @(posedge clk);
      #1;
      i_req = 1'b0;
      d_req = 1'b0;
      d_we  = 4'b0000;
   endtask

   task automatic check_reset_vals();
      check_eq("rst_m_req", 32'(m_req), 32'd0);
      check_eq("rst_m_we", 32'(m_we), 32'd0);
      check_eq("rst_m_addr", m_addr, 32'h0);
      check_eq("rst_m_wdata", m_wdata, 32'h0);
      check_eq("rst_acks", {30'b0, i_ack, d_ack}, 32'd0);
      check_eq("rst_i_rdata", i_rdata, 32'h0);
      check_eq("rst_d_rdata", d_rdata, 32'h0);
      check_eq("rst_err", 32'(err), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 4'b0000; d_addr = 32'h0; d_wdata = 32'h0;
      #2;
      check_reset_vals();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Contention from reset.
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_addr = 32'h3000;
`ifdef ARB_RR_EN
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      exp_q.push_back('{1'b0, mdata(32'h200)});
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      exp_q.push_back('{1'b0, mdata(32'h200)});
      wait_acks(4, 1'b1);
`else
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      wait_acks(3, 1'b1);
`endif
      release_reqs();

      // Lone zero-wait fetch.
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h100;
      exp_q.push_back('{1'b0, 32'h00500093});
      repeat (2) @(negedge clk);
      check_eq("fetch_m_req", 32'(m_req), 32'd1);
      check_eq("fetch_m_addr", m_addr, 32'h100);
      check_eq("fetch_m_we", 32'(m_we), 32'd0);
      @(negedge clk);
      check_eq("fetch_i_ack_c2", 32'(i_ack), 32'd1);
      check_eq("fetch_d_ack", 32'(d_ack), 32'd0);
      release_reqs();

      // Lone load so d_rdata holds a known value before the store.
      @(posedge clk); #1;
      d_req = 1'b1; d_addr = 32'h3008;
      exp_drd = mdata(32'h3008);
      exp_q.push_back('{1'b1, exp_drd});
      wait_acks(1, 1'b0);
      release_reqs();

      // Store with two memory wait cycles.
      mem_wait = 2;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
      exp_q.push_back('{1'b1, exp_drd});
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("store_m_req", 32'(m_req), 32'd1);
         check_eq("store_m_we", 32'(m_we), 32'h3);
         check_eq("store_m_wdata", m_wdata, 32'hDEADBEEF);
      end
      @(negedge clk);
      check_eq("store_d_ack_c4", 32'(d_ack), 32'd1);
      check_eq("store_we_clr", 32'(m_we), 32'd0);
      release_reqs();
      mem_wait = 0;

      // Contention after a data grant: round-robin now favours the fetch.
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_addr = 32'h3000;
`ifdef ARB_RR_EN
      exp_q.push_back('{1'b0, mdata(32'h200)});
      exp_q.push_back('{1'b1, mdata(32'h3000)});
`else
      exp_q.push_back('{1'b1, mdata(32'h3000)});
      exp_q.push_back('{1'b1, mdata(32'h3000)});
`endif
      wait_acks(2, 1'b1);
      release_reqs();

      // Watchdog: memory never acks.
      mem_en = 1'b0;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h400;
      exp_q.push_back('{1'b0, 32'h0});
      reqc = 0;
      got = 1'b0;
      for (int cyc = 0; cyc < 40 && !got; cyc++) begin
         @(negedge clk);
         if (m_req) reqc++;
         if (i_ack) got = 1'b1;
      end
      check_eq("wdog_ack_seen", 32'(got), 32'd1);
      check_eq("wdog_m_req_cycles", 32'(reqc), 32'd5);
      check_eq("wdog_err", 32'(err), 32'd1);
      release_reqs();
      @(posedge clk); #1 stray = 1'b1;
      repeat (2) @(posedge clk);
      #1 stray = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("late_ack_no_req", 32'(m_req), 32'd0);
         check_eq("late_ack_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
      end
      check_eq("err_sticky", 32'(err), 32'd1);

      // Asynchronous reset in BUSY_D.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h5000; d_wdata = 32'h12345678;
      repeat (2) @(negedge clk);
      check_eq("busy_d_m_req", 32'(m_req), 32'd1);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 4'b0000;
      mem_en = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h100;
      exp_q.push_back('{1'b0, 32'h00500093});
      wait_acks(1, 1'b0);
      check_eq("post_rst_err", 32'(err), 32'd0);
      release_reqs();

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
